// File: rtl/mioc_pkg.sv
// Shared definitions for the MIOC flop pattern checker.
//   state_t : sequencer states (IDLE, PRE, APPLY, DONE)
//   PAT_W   : stimulus pattern width
//   CNT_W   : mismatch counter width (holds up to 16)
//   RES_W   : width of one result entry, {q, qbar}
package mioc_pkg;

    localparam int unsigned PAT_W = 4;
    localparam int unsigned CNT_W = 5;
    localparam int unsigned RES_W = 2;

    typedef enum logic [1:0] {
        IDLE,
        PRE,
        APPLY,
        DONE
    } state_t;

endpackage

// File: rtl/mioc_sync2.sv
// Generic 2-flop synchronizer.
//   clk   : destination clock
//   rst_n : synchronous active-low reset, clears both stages
//   d     : asynchronous input
//   q     : synchronized output, two clocks behind d
module mioc_sync2 #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/mioc_flop_pattern_checker.sv
// On-chip stimulus sequencer and response checker for the MIOC NMOS register
// cell. A start pulse runs a zero pre-dwell, then patterns 0..NUM_PATTERNS-1,
// each held HOLD_CYCLES clocks. The synchronized {q, qbar} is captured in the
// last cycle of each dwell into a readable result buffer.
//   clk, rst_n        : clock, synchronous active-low reset
//   start             : run request, honoured only in IDLE
//   q, qbar           : cell outputs (asynchronous)
//   in1..in4          : cell stimulus, in1 = pattern[3], in4 = pattern[0]
//   busy, done        : run in progress / one-cycle completion pulse
//   mismatch_cnt      : patterns where q differed from EXP_VEC[p]
//   comp_err          : sticky, some sample had q == qbar
//   rd_addr, rd_data  : registered result buffer read port
module mioc_flop_pattern_checker
    import mioc_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES  = 100,
    parameter int unsigned NUM_PATTERNS = 16,
    parameter logic [15:0] EXP_VEC      = 16'h0000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             q,
    input  logic             qbar,
    output logic             in1,
    output logic             in2,
    output logic             in3,
    output logic             in4,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] mismatch_cnt,
    output logic             comp_err,
    input  logic [3:0]       rd_addr,
    output logic [RES_W-1:0] rd_data
);

    localparam int unsigned DW_W = $clog2(HOLD_CYCLES);
    localparam logic [DW_W-1:0]  DWELL_LAST = DW_W'(HOLD_CYCLES - 1);
    localparam logic [PAT_W-1:0] PAT_LAST   = PAT_W'(NUM_PATTERNS - 1);

    state_t             state;
    logic [DW_W-1:0]    dwell;
    logic [PAT_W-1:0]   pat;
    logic [PAT_W-1:0]   stim;
    logic [RES_W-1:0]   result [16];
    logic               q_s;
    logic               qbar_s;

    mioc_sync2 #(.WIDTH(1)) u_sync_q (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (q),
        .q     (q_s)
    );

    mioc_sync2 #(.WIDTH(1)) u_sync_qbar (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (qbar),
        .q     (qbar_s)
    );

    assign in1 = stim[3];
    assign in2 = stim[2];
    assign in3 = stim[1];
    assign in4 = stim[0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            dwell        <= '0;
            pat          <= '0;
            stim         <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            mismatch_cnt <= '0;
            comp_err     <= 1'b0;
            rd_data      <= '0;
            for (int unsigned i = 0; i < 16; i++) begin
                result[i] <= '0;
            end
        end else begin
            done    <= 1'b0;
            // Nonblocking read: same-edge writes are seen on the next read.
            rd_data <= result[rd_addr];
            case (state)
                IDLE: begin
                    stim <= '0;
                    if (start) begin
                        state        <= PRE;
                        dwell        <= '0;
                        busy         <= 1'b1;
                        mismatch_cnt <= '0;
                        comp_err     <= 1'b0;
                        for (int unsigned i = 0; i < 16; i++) begin
                            result[i] <= '0;
                        end
                    end
                end
                PRE: begin
                    if (dwell == DWELL_LAST) begin
                        state <= APPLY;
                        dwell <= '0;
                        pat   <= '0;
                        stim  <= '0;
                    end else begin
                        dwell <= dwell + DW_W'(1);
                    end
                end
                APPLY: begin
                    if (dwell == DWELL_LAST) begin
                        dwell       <= '0;
                        result[pat] <= {q_s, qbar_s};
                        if (q_s != EXP_VEC[pat]) begin
                            mismatch_cnt <= mismatch_cnt + CNT_W'(1);
                        end
                        if (q_s == qbar_s) begin
                            comp_err <= 1'b1;
                        end
                        if (pat == PAT_LAST) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            stim  <= '0;
                        end else begin
                            pat  <= pat + PAT_W'(1);
                            stim <= pat + PAT_W'(1);
                        end
                    end else begin
                        dwell <= dwell + DW_W'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                    stim  <= '0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mioc_flop_pattern_checker.sv
module tb_mioc_flop_pattern_checker;

    localparam int unsigned HA = 4;
    localparam int unsigned NA = 16;
    localparam logic [15:0] EXP_A = 16'hFF00;
    localparam int unsigned HB = 4;
    localparam int unsigned NB = 6;
    localparam logic [15:0] EXP_B = 16'h0015;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic       start_a = 1'b0, start_b = 1'b0;
    logic       q_a, qbar_a, q_b, qbar_b;
    logic       in1_a, in2_a, in3_a, in4_a, in1_b, in2_b, in3_b, in4_b;
    logic       busy_a, done_a, comp_a, busy_b, done_b, comp_b;
    logic [4:0] mism_a, mism_b;
    logic [3:0] rd_addr_a = '0, rd_addr_b = '0;
    logic [1:0] rd_data_a, rd_data_b;

    // Cell behaviour tables: q/qbar as a function of the applied pattern.
    logic [15:0] tq_a = '0, tqb_a = '0, tq_b = '0, tqb_b = '0;
    logic [3:0]  pat_a, pat_b;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;
    int unsigned done_cnt_a = 0, done_cnt_b = 0, overlap = 0;

    assign pat_a  = {in1_a, in2_a, in3_a, in4_a};
    assign pat_b  = {in1_b, in2_b, in3_b, in4_b};
    assign q_a    = tq_a[pat_a];
    assign qbar_a = tqb_a[pat_a];
    assign q_b    = tq_b[pat_b];
    assign qbar_b = tqb_b[pat_b];

    always #5 clk = ~clk;

    mioc_flop_pattern_checker #(.HOLD_CYCLES(HA), .NUM_PATTERNS(NA), .EXP_VEC(EXP_A)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .q(q_a), .qbar(qbar_a),
        .in1(in1_a), .in2(in2_a), .in3(in3_a), .in4(in4_a),
        .busy(busy_a), .done(done_a), .mismatch_cnt(mism_a), .comp_err(comp_a),
        .rd_addr(rd_addr_a), .rd_data(rd_data_a)
    );

    mioc_flop_pattern_checker #(.HOLD_CYCLES(HB), .NUM_PATTERNS(NB), .EXP_VEC(EXP_B)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .q(q_b), .qbar(qbar_b),
        .in1(in1_b), .in2(in2_b), .in3(in3_b), .in4(in4_b),
        .busy(busy_b), .done(done_b), .mismatch_cnt(mism_b), .comp_err(comp_b),
        .rd_addr(rd_addr_b), .rd_data(rd_data_b)
    );

    always @(negedge clk) begin
        if (done_a === 1'b1) done_cnt_a++;
        if (done_b === 1'b1) done_cnt_b++;
        if ((busy_a && done_a) || (busy_b && done_b)) overlap++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: mismatches, comp_err and buffer contents derived directly
    // from the cell table and the expected vector.
    task automatic check_a(input string tag);
        int unsigned m = 0;
        logic ce = 1'b0;
        logic [1:0] e;
        for (int p = 0; p < int'(NA); p++) begin
            if (tq_a[p] != EXP_A[p]) m++;
            if (tq_a[p] == tqb_a[p]) ce = 1'b1;
        end
        chk({tag, "_mismatch_cnt"}, 32'(mism_a), m);
        chk({tag, "_comp_err"}, 32'(comp_a), 32'(ce));
        for (int a = 0; a < 16; a++) begin
            rd_addr_a = 4'(a);
            tick();
            e = (a < int'(NA)) ? {tq_a[a], tqb_a[a]} : 2'b00;
            chk($sformatf("%s_entry%0d", tag, a), 32'(rd_data_a), 32'(e));
        end
    endtask

    task automatic run_a(input string tag);
        int lat = -1;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        chk({tag, "_busy_after_start"}, 32'(busy_a), 1);
        for (int i = 1; i <= 400; i++) begin
            tick();
            if (done_a === 1'b1) begin
                lat = i;
                break;
            end
        end
        chk({tag, "_done_latency"}, lat, (NA + 1) * HA);
        chk({tag, "_busy_at_done"}, 32'(busy_a), 0);
        chk({tag, "_stim_at_done"}, 32'(pat_a), 0);
        tick();
        chk({tag, "_done_one_cycle"}, 32'(done_a), 0);
    endtask

    task automatic set_pass_a();
        for (int p = 0; p < 16; p++) begin
            tq_a[p]  = p[3];
            tqb_a[p] = ~p[3];
        end
    endtask

    initial begin
        int lat;
        int unsigned dc;
        logic [1:0] e;

        // Reset state
        repeat (3) tick();
        chk("rst_stim", 32'(pat_a), 0);
        chk("rst_busy", 32'(busy_a), 0);
        chk("rst_done", 32'(done_a), 0);
        chk("rst_mism", 32'(mism_a), 0);
        chk("rst_comp", 32'(comp_a), 0);
        chk("rst_rd_data", 32'(rd_data_a), 0);
        rst_n = 1'b1;
        repeat (2) tick();

        // Pass-through cell
        set_pass_a();
        run_a("pass");
        check_a("pass");

        // Stuck q=0, qbar=1
        tq_a  = 16'h0000;
        tqb_a = 16'hFFFF;
        run_a("stuck");
        check_a("stuck");

        // Pass-through with q=qbar=1 during pattern 5
        set_pass_a();
        tq_a[5]  = 1'b1;
        tqb_a[5] = 1'b1;
        run_a("force5");
        check_a("force5");

        // Random cell behaviour
        for (int r = 0; r < 4; r++) begin
            tq_a  = 16'($urandom);
            tqb_a = 16'($urandom);
            run_a($sformatf("rand%0d", r));
            check_a($sformatf("rand%0d", r));
        end

        // Reset during pattern 7
        set_pass_a();
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        repeat (8 * HA + 2) tick();
        chk("midrst_pattern7", 32'(pat_a), 7);
        dc = done_cnt_a;
        rst_n = 1'b0;
        tick();
        chk("midrst_stim", 32'(pat_a), 0);
        chk("midrst_busy", 32'(busy_a), 0);
        chk("midrst_mism", 32'(mism_a), 0);
        chk("midrst_comp", 32'(comp_a), 0);
        rst_n = 1'b1;
        repeat (100) tick();
        chk("midrst_no_done", done_cnt_a, dc);
        for (int a = 0; a < 16; a++) begin
            rd_addr_a = 4'(a);
            tick();
            chk($sformatf("midrst_entry%0d", a), 32'(rd_data_a), 0);
        end

        // NUM_PATTERNS=6, start re-pulsed during pattern 3
        for (int p = 0; p < 16; p++) begin
            tq_b[p]  = p[0];
            tqb_b[p] = ~p[0];
        end
        dc = done_cnt_b;
        lat = -1;
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        for (int i = 1; i <= 200; i++) begin
            start_b = (i == 4 * int'(HB) + 2) ? 1'b1 : 1'b0;
            tick();
            start_b = 1'b0;
            if (done_b === 1'b1 && lat < 0) lat = i;
            if (i == 4 * int'(HB) + 2) chk("restart_pattern3", 32'(pat_b), 3);
            if (lat >= 0 && i > lat + 40) break;
        end
        chk("restart_latency", lat, (NB + 1) * HB);
        chk("restart_one_done", done_cnt_b - dc, 1);
        // EXP_B = 0x15: patterns 0,2,4 expect 1; q = p[0] so all six differ
        chk("restart_mism", 32'(mism_b), 6);
        chk("restart_comp", 32'(comp_b), 0);
        for (int a = 0; a < 16; a++) begin
            rd_addr_b = 4'(a);
            tick();
            e = (a < int'(NB)) ? {tq_b[a], tqb_b[a]} : 2'b00;
            chk($sformatf("restart_entry%0d", a), 32'(rd_data_b), 32'(e));
        end

        chk("busy_done_overlap", overlap, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
